// File: rtl/dsc_pkg.sv
// Shared types and default widths for the DSC slice controller.
package dsc_pkg;

    localparam int unsigned DSC_DIM_W = 16;
    localparam int unsigned DSC_IDX_W = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } dsc_state_t;

    typedef struct packed {
        logic [DSC_DIM_W-1:0] pic_w;
        logic [DSC_DIM_W-1:0] pic_h;
        logic [DSC_DIM_W-1:0] slice_w;
        logic [DSC_DIM_W-1:0] slice_h;
    } dsc_cfg_t;

    typedef struct packed {
        logic [DSC_DIM_W-1:0] x;
        logic [DSC_DIM_W-1:0] y;
        logic [DSC_DIM_W-1:0] w;
        logic [DSC_DIM_W-1:0] h;
        logic [DSC_IDX_W-1:0] idx;
    } dsc_slice_cmd_t;

endpackage

// File: rtl/dsc_slice_geom.sv
// Combinational raster step: next slice origin, its clipped size, and end-of-frame detect.
module dsc_slice_geom
    import dsc_pkg::*;
#(
    parameter int unsigned DIM_W = DSC_DIM_W
) (
    input  logic [DIM_W-1:0] pic_w,
    input  logic [DIM_W-1:0] pic_h,
    input  logic [DIM_W-1:0] slice_w,
    input  logic [DIM_W-1:0] slice_h,
    input  logic [DIM_W-1:0] x,
    input  logic [DIM_W-1:0] y,
    output logic [DIM_W-1:0] next_x,
    output logic [DIM_W-1:0] next_y,
    output logic [DIM_W-1:0] next_w,
    output logic [DIM_W-1:0] next_h,
    output logic             last
);

    logic [DIM_W:0]   sum_x;
    logic [DIM_W:0]   sum_y;
    logic             wrap;
    logic [DIM_W-1:0] rem_w;
    logic [DIM_W-1:0] rem_h;

    // One extra bit so x+slice_w / y+slice_h cannot wrap before the compare.
    assign sum_x  = {1'b0, x} + {1'b0, slice_w};
    assign wrap   = (sum_x >= {1'b0, pic_w});
    assign next_x = wrap ? '0 : sum_x[DIM_W-1:0];
    assign sum_y  = wrap ? ({1'b0, y} + {1'b0, slice_h}) : {1'b0, y};
    assign last   = (sum_y >= {1'b0, pic_h});
    assign next_y = sum_y[DIM_W-1:0];

    assign rem_w  = pic_w - next_x;
    assign rem_h  = last ? '0 : (pic_h - next_y);
    assign next_w = (slice_w < rem_w) ? slice_w : rem_w;
    assign next_h = (slice_h < rem_h) ? slice_h : rem_h;

endmodule

// File: rtl/dsc_slice_ctrl.sv
// Frame slicer: validates a picture/slice configuration and issues clipped slice commands in raster order.
module dsc_slice_ctrl
    import dsc_pkg::*;
#(
    parameter int unsigned DIM_W = DSC_DIM_W,
    parameter int unsigned IDX_W = DSC_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic [DIM_W-1:0] cfg_pic_w,
    input  logic [DIM_W-1:0] cfg_pic_h,
    input  logic [DIM_W-1:0] cfg_slice_w,
    input  logic [DIM_W-1:0] cfg_slice_h,
    input  logic             abort,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err,
    output logic             slc_valid,
    input  logic             slc_ready,
    output logic [DIM_W-1:0] slc_x,
    output logic [DIM_W-1:0] slc_y,
    output logic [DIM_W-1:0] slc_w,
    output logic [DIM_W-1:0] slc_h,
    output logic [IDX_W-1:0] slc_idx,
    input  logic             slc_done,
    output logic             proto_err
);

    localparam int unsigned CNT_W = 2 * DIM_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1) << IDX_W;

    dsc_state_t       state;
    logic [DIM_W-1:0] pic_w_q, pic_h_q, slice_w_q, slice_h_q;
    logic [DIM_W-1:0] x_q, y_q, w_q, h_q;
    logic [IDX_W-1:0] idx_q;

    logic [DIM_W-1:0] nx, ny, nw, nh;
    logic             last;

    logic [DIM_W:0]   sw_div, sh_div, cols, rows;
    logic [CNT_W-1:0] slice_cnt;
    logic             cfg_bad;

    assign slc_x   = x_q;
    assign slc_y   = y_q;
    assign slc_w   = w_q;
    assign slc_h   = h_q;
    assign slc_idx = idx_q;

    dsc_slice_geom #(.DIM_W(DIM_W)) u_geom (
        .pic_w   (pic_w_q),
        .pic_h   (pic_h_q),
        .slice_w (slice_w_q),
        .slice_h (slice_h_q),
        .x       (x_q),
        .y       (y_q),
        .next_x  (nx),
        .next_y  (ny),
        .next_w  (nw),
        .next_h  (nh),
        .last    (last)
    );

    // Zero divisors are replaced by 1; such configs are rejected by the zero test anyway.
    always_comb begin
        sw_div    = (slice_w_q == '0) ? (DIM_W+1)'(1) : {1'b0, slice_w_q};
        sh_div    = (slice_h_q == '0) ? (DIM_W+1)'(1) : {1'b0, slice_h_q};
        cols      = ({1'b0, pic_w_q} + {1'b0, slice_w_q} - (DIM_W+1)'(1)) / sw_div;
        rows      = ({1'b0, pic_h_q} + {1'b0, slice_h_q} - (DIM_W+1)'(1)) / sh_div;
        slice_cnt = CNT_W'(cols) * CNT_W'(rows);
        cfg_bad   = (pic_w_q == '0) || (pic_h_q == '0) ||
                    (slice_w_q == '0) || (slice_h_q == '0) ||
                    (slice_w_q > pic_w_q) || (slice_h_q > pic_h_q) ||
                    (slice_cnt > CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            slc_valid  <= 1'b0;
            proto_err  <= 1'b0;
            pic_w_q    <= '0;
            pic_h_q    <= '0;
            slice_w_q  <= '0;
            slice_h_q  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            idx_q      <= '0;
        end else begin
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            if (slc_done && state != S_WAIT) begin
                proto_err <= 1'b1;
            end
            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                slc_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cfg_start) begin
                            pic_w_q   <= cfg_pic_w;
                            pic_h_q   <= cfg_pic_h;
                            slice_w_q <= cfg_slice_w;
                            slice_h_q <= cfg_slice_h;
                            proto_err <= 1'b0;
                            busy      <= 1'b1;
                            state     <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            x_q       <= '0;
                            y_q       <= '0;
                            w_q       <= slice_w_q;
                            h_q       <= slice_h_q;
                            idx_q     <= '0;
                            slc_valid <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (slc_ready) begin
                            slc_valid <= 1'b0;
                            state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (slc_done) begin
                            state <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        x_q   <= nx;
                        y_q   <= ny;
                        idx_q <= idx_q + IDX_W'(1);
                        if (last) begin
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            w_q       <= nw;
                            h_q       <= nh;
                            slc_valid <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy      <= 1'b0;
                        slc_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsc_slice_ctrl.sv
// Randomized bench for dsc_slice_ctrl against a raster-loop reference of the slicing rules.
module tb_dsc_slice_ctrl;
    import dsc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic [15:0] cfg_pic_w, cfg_pic_h, cfg_slice_w, cfg_slice_h;
    logic        abort;
    logic        busy, frame_done, cfg_err, slc_valid, slc_ready;
    logic [15:0] slc_x, slc_y, slc_w, slc_h;
    logic [11:0] slc_idx;
    logic        slc_done;
    logic        proto_err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    dsc_slice_ctrl #(.DIM_W(16), .IDX_W(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_start   (cfg_start),
        .cfg_pic_w   (cfg_pic_w),
        .cfg_pic_h   (cfg_pic_h),
        .cfg_slice_w (cfg_slice_w),
        .cfg_slice_h (cfg_slice_h),
        .abort       (abort),
        .busy        (busy),
        .frame_done  (frame_done),
        .cfg_err     (cfg_err),
        .slc_valid   (slc_valid),
        .slc_ready   (slc_ready),
        .slc_x       (slc_x),
        .slc_y       (slc_y),
        .slc_w       (slc_w),
        .slc_h       (slc_h),
        .slc_idx     (slc_idx),
        .slc_done    (slc_done),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Runs one frame; abort_idx/stall_idx of -1 disable those behaviours.
    task automatic run_frame(input int pw, input int ph, input int sw, input int sh,
                             input int rdy_pct, input int dly, input int abort_idx,
                             input int stall_idx);
        dsc_slice_cmd_t exp_q[$];
        dsc_slice_cmd_t c;
        logic [75:0]    cur, held;
        longint         cnt;
        bit             bad, held_valid, outstanding, aborted;
        int             k, fd, wait_cnt, stall_n, budget, n;

        bad = (pw == 0) || (ph == 0) || (sw == 0) || (sh == 0) || (sw > pw) || (sh > ph);
        if (!bad) begin
            cnt = longint'((pw + sw - 1) / sw) * longint'((ph + sh - 1) / sh);
            bad = (cnt > 4096);
        end
        if (!bad) begin
            n = 0;
            for (int y = 0; y < ph; y += sh) begin
                for (int x = 0; x < pw; x += sw) begin
                    c.x   = 16'(x);
                    c.y   = 16'(y);
                    c.w   = 16'(min2(sw, pw - x));
                    c.h   = 16'(min2(sh, ph - y));
                    c.idx = 12'(n);
                    exp_q.push_back(c);
                    n++;
                end
            end
        end

        @(negedge clk);
        cfg_pic_w = 16'(pw);  cfg_pic_h = 16'(ph);
        cfg_slice_w = 16'(sw); cfg_slice_h = 16'(sh);
        cfg_start = 1'b1; slc_ready = 1'b0; slc_done = 1'b0; abort = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("proto_err_cleared", proto_err, 0);
        chk("no_valid_in_check", slc_valid, 0);
        @(negedge clk);
        if (bad) begin
            chk("cfg_err_pulse", cfg_err, 1);
            chk("bad_no_valid", slc_valid, 0);
            chk("bad_busy_low", busy, 0);
            @(negedge clk);
            chk("cfg_err_one_cycle", cfg_err, 0);
            chk("bad_still_no_valid", slc_valid, 0);
            return;
        end
        chk("no_cfg_err", cfg_err, 0);
        chk("first_valid_latency", slc_valid, 1);

        k = 0; fd = 0; wait_cnt = 0; stall_n = 0;
        held_valid = 0; outstanding = 0; aborted = 0; held = '0;
        budget = 30 * exp_q.size() + 60;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cyc > 0) @(negedge clk);
            cur = {slc_x, slc_y, slc_w, slc_h, slc_idx};
            if (held_valid) begin
                chk("hold_valid", slc_valid, 1);
                chk("hold_fields", cur, held);
            end
            if (slc_valid) chk("single_outstanding", outstanding, 0);
            if (frame_done) begin
                fd++;
                chk("done_after_all_cmds", k, exp_q.size());
                break;
            end
            slc_done = 1'b0;
            abort = 1'b0;
            if (outstanding) begin
                if (wait_cnt == 0) begin
                    if (k - 1 == abort_idx) begin
                        abort = 1'b1;
                        aborted = 1;
                    end else begin
                        slc_done = 1'b1;
                    end
                    outstanding = 0;
                end else begin
                    wait_cnt--;
                end
            end
            if (slc_valid && int'(slc_idx) == stall_idx && stall_n < 5) begin
                slc_ready = 1'b0;
                stall_n++;
            end else begin
                slc_ready = ($urandom_range(99) < rdy_pct);
            end
            held_valid = slc_valid && !slc_ready;
            held = cur;
            if (slc_valid && slc_ready) begin
                if (k < exp_q.size()) chk("cmd", 128'(cur), 128'(exp_q[k]));
                else chk("extra_cmd", k, exp_q.size());
                k++;
                outstanding = 1;
                wait_cnt = dly - 1;
            end
            if (aborted) break;
        end

        if (aborted) begin
            @(negedge clk);
            abort = 1'b0;
            chk("abort_cmd_count", k, abort_idx + 1);
            chk("abort_busy_low", busy, 0);
            chk("abort_valid_low", slc_valid, 0);
            chk("abort_no_done", frame_done, 0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("abort_quiet", {frame_done, slc_valid, busy}, 0);
            end
        end else begin
            chk("frame_done_count", fd, 1);
            chk("cmd_count", k, exp_q.size());
            slc_done = 1'b0;
            @(negedge clk);
            chk("idle_busy_low", busy, 0);
            chk("frame_done_one_cycle", frame_done, 0);
            chk("no_proto_err", proto_err, 0);
        end
        slc_ready = 1'b0;
    endtask

    task automatic reset_mid_issue();
        @(negedge clk);
        cfg_pic_w = 16'd64; cfg_pic_h = 16'd32; cfg_slice_w = 16'd32; cfg_slice_h = 16'd16;
        cfg_start = 1'b1; slc_ready = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", slc_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_flags", {busy, frame_done, cfg_err, slc_valid, proto_err}, 0);
        chk("rst_xy", {slc_x, slc_y}, 0);
        chk("rst_whi", {slc_w, slc_h, slc_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_idle", {busy, slc_valid}, 0);
        end
        slc_done = 1'b1;
        @(negedge clk);
        slc_done = 1'b0;
        chk("proto_err_set", proto_err, 1);
        @(negedge clk);
        chk("proto_err_sticky", proto_err, 1);
    endtask

    initial begin
        int pw, ph, sw, sh;
        rst_n = 1'b0; cfg_start = 1'b0; abort = 1'b0; slc_ready = 1'b0; slc_done = 1'b0;
        cfg_pic_w = '0; cfg_pic_h = '0; cfg_slice_w = '0; cfg_slice_h = '0;
        #2;
        chk("reset_flags", {busy, frame_done, cfg_err, slc_valid, proto_err}, 0);
        chk("reset_xy", {slc_x, slc_y}, 0);
        chk("reset_whi", {slc_w, slc_h, slc_idx}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(64, 32, 32, 16, 100, 3, -1, -1);
        run_frame(70, 20, 32, 16, 100, 1, -1, -1);
        run_frame(64, 32, 0, 16, 100, 1, -1, -1);
        run_frame(64, 32, 32, 40, 100, 1, -1, -1);
        run_frame(0, 32, 16, 16, 100, 1, -1, -1);
        run_frame(4097, 1, 1, 1, 100, 1, -1, -1);
        run_frame(64, 32, 16, 16, 100, 2, -1, 1);
        run_frame(96, 48, 32, 16, 100, 2, 2, -1);
        run_frame(96, 48, 32, 16, 70, 2, -1, -1);
        reset_mid_issue();
        run_frame(50, 50, 16, 16, 60, 1, -1, -1);
        run_frame(4096, 1, 1, 1, 100, 1, -1, -1);

        for (int t = 0; t < 25; t++) begin
            pw = $urandom_range(1, 100);
            ph = $urandom_range(1, 100);
            sw = $urandom_range(1, pw + 8);
            sh = $urandom_range(1, ph + 8);
            run_frame(pw, ph, sw, sh, $urandom_range(30, 100), $urandom_range(1, 4),
                      -1, ($urandom_range(3) == 0) ? 0 : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
